// File: rtl/spike_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : spike_event_logger
// Purpose  : Timestamps spikes from a LIF neuron with a free-running cycle
//            counter, buffers the timestamps in a FIFO drained through a
//            valid/ready handshake, and reports a per-window spike count.
// Ports    : clk, reset_n (async, active-low)
//            enable        - gates timestamp counter, window counter, capture
//            spike_in      - spike from the neuron
//            ev_valid/ev_ready/ev_timestamp - head-of-FIFO event handshake
//            fifo_level    - occupied FIFO entries
//            overflow      - sticky, a spike was dropped on a full FIFO
//            drop_count    - saturating count of dropped spikes
//            win_count     - spike count of the last completed window
//            win_valid     - one-cycle pulse when win_count updates
// Options  : SPIKE_EDGE_DETECT_EN - when defined, only a rising edge of
//            spike_in is an event; otherwise every enabled high cycle is.
// Revision : 1.0 - initial release
// ============================================================================
module spike_event_logger #(
   parameter int TS_WIDTH  = 16,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 8,
   parameter int WINDOW    = 100
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      spike_in,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [TS_WIDTH-1:0]       ev_timestamp,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow,
   output logic [CNT_WIDTH-1:0]      drop_count,
   output logic [CNT_WIDTH-1:0]      win_count,
   output logic                      win_valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int WC_W  = $clog2(WINDOW);

   localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]     LVL_ONE  = LVL_W'(1);
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [WC_W-1:0]      WC_LAST  = WC_W'(WINDOW - 1);
   localparam logic [WC_W-1:0]      WC_ONE   = WC_W'(1);
   localparam logic [TS_WIDTH-1:0]  TS_ONE   = TS_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [TS_WIDTH-1:0]  ts;
   logic [TS_WIDTH-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level;
   logic [WC_W-1:0]      wc;
   logic [CNT_WIDTH-1:0] acc;

   logic                 spike_event;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 drop;
   logic                 win_end;
   logic [CNT_WIDTH-1:0] acc_next;

   // ------------------------------------------------------------------------
   // Spike event detection
   // ------------------------------------------------------------------------
`ifdef SPIKE_EDGE_DETECT_EN
   logic spike_prev;

   // Previous value only advances while enabled, so a level held across a
   // disabled stretch is not seen as a fresh edge on re-enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         spike_prev <= 1'b0;
      else if (enable)
         spike_prev <= spike_in;
   end

   assign spike_event = enable & spike_in & ~spike_prev;
`else
   assign spike_event = enable & spike_in;
`endif

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   assign ev_valid = (level != '0);
   assign full     = (level == LVL_FULL);
   assign pop      = ev_valid & ev_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = spike_event & (~full | pop);
   assign drop     = spike_event & full & ~pop;

   // Head read is qualified by ev_valid so that reset (or an empty FIFO)
   // never exposes stale storage contents.
   assign ev_timestamp = ev_valid ? mem[rd_ptr] : '0;
   assign fifo_level   = level;

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= ts;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts         <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (enable)
            ts <= ts + TS_ONE;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != CNT_MAX)
               drop_count <= drop_count + CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Window rate counter
   // ------------------------------------------------------------------------
   assign win_end = enable & (wc == WC_LAST);

   // Accumulator including this cycle's spike; dropped spikes still count.
   always_comb begin
      acc_next = acc;
      if (spike_event && (acc != CNT_MAX))
         acc_next = acc + CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wc        <= '0;
         acc       <= '0;
         win_count <= '0;
         win_valid <= 1'b0;
      end else begin
         win_valid <= win_end;
         if (win_end) begin
            win_count <= acc_next;
            acc       <= '0;
            wc        <= '0;
         end else if (enable) begin
            acc <= acc_next;
            wc  <= wc + WC_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
Downstream consumer of the LIF neuron's `spike_out`. It timestamps each spike with a free-running cycle counter and buffers the timestamps in a FIFO, which a readout master drains via a valid/ready handshake. It also reports a per-window spike count for rate monitoring.

Parameters:
- TS_WIDTH, 16, timestamp counter width; wraps modulo 2^TS_WIDTH.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- CNT_WIDTH, 8, width of the window count and the drop count; both saturate.
- WINDOW, 100, window length in enabled cycles; at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run enable. Gates the timestamp counter, the window counter and spike capture.
- spike_in  in  1  spike from the neuron, sampled on posedge clk.
- ev_valid  out  1  FIFO head holds a valid event.
- ev_ready  in  1  consumer accepts the head event.
- ev_timestamp  out  TS_WIDTH  timestamp of the head event.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky; set when a spike is dropped.
- drop_count  out  CNT_WIDTH  number of dropped spikes, saturating.
- win_count  out  CNT_WIDTH  spike count of the last completed window.
- win_valid  out  1  one-cycle pulse when `win_count` updates.

Behaviour:
- Reset (asynchronous): all counters zero, FIFO empty.
  - ev_valid=0, ev_timestamp=0, fifo_level=0.
  - overflow=0, drop_count=0, win_count=0, win_valid=0.
- Timestamp counter `ts`:
  - Increments by 1 each cycle when enable=1; holds when enable=0.
  - Wraps from 2^TS_WIDTH-1 to 0.
- Spike event: enable=1 and spike_in=1 in a cycle.
  - The event carries the `ts` value of that cycle, i.e. the value before the increment.
  - Each high cycle is one event, so consecutive high cycles give consecutive timestamps.
- Push: on a spike event, provided the FIFO is not full or a pop occurs in the same cycle.
- Pop: when ev_valid && ev_ready.
- Latency:
  - A pushed event is visible at the FIFO head one cycle later at the earliest. There is no same-cycle bypass.
  - `ev_timestamp` is registered or read from the head entry. It is stable while ev_valid=1 and ev_ready=0.
- Ordering: events leave in strict FIFO order.
- Full FIFO, no pop, spike event:
  - The event is dropped.
  - overflow is set (sticky until reset).
  - drop_count increments, saturating at 2^CNT_WIDTH-1.
- Full FIFO, pop and push in the same cycle: both happen; level is unchanged at DEPTH; no drop.
- Empty FIFO with ev_ready=1: nothing pops; ev_valid stays 0.
- Simultaneous push and pop at any level: level is unchanged.
- Read and write pointers wrap modulo DEPTH.
- Window logic (counts only while enable=1):
  - Cycle counter `wc` runs 0..WINDOW-1.
  - Spike accumulator `acc` counts spike events, saturating at 2^CNT_WIDTH-1. Dropped spikes are still counted.
  - In the cycle where wc==WINDOW-1:
    - win_count <= acc plus this cycle's spike (saturating).
    - acc <= 0, wc <= 0.
    - win_valid=1 in the following cycle, for exactly one cycle.
  - enable=0 freezes `wc` and `acc`; win_valid stays 0.
- Enable low: spikes are ignored and `ts` is frozen. FIFO pops continue to work.
- Reset mid-operation: all state clears immediately, including FIFO contents; no stale event is presented.
- No combinational path from spike_in to any output.

Optional Feature:
- Macro: SPIKE_EDGE_DETECT_EN.
- Defined:
  - A spike event is a rising edge of spike_in: spike_in=1 and registered previous spike_in=0, with enable=1.
  - The previous-value register resets to 0 and updates only when enable=1.
  - A level held high for N cycles produces one event.
- Undefined: every enabled high cycle is an event, as described in Behaviour.

Test Plan:
- Basic capture:
  - Stimulus: reset, enable=1, ev_ready=0; spike_in pulses at ts=5, 9 and 12.
  - Required: fifo_level=3; ev_valid=1; ev_timestamp=5.
  - Then ev_ready=1: pops yield 5, 9, 12; ev_valid=0 afterwards.
- Overflow:
  - Stimulus: DEPTH=8, ev_ready=0, spike_in held high 10 cycles from ts=0.
  - Required: fifo_level=8; overflow=1; drop_count=2; drained timestamps are 0..7.
- Full-boundary push and pop:
  - Stimulus: fill to 8, then assert spike_in and ev_ready together for one cycle.
  - Required: level stays 8, no drop, head advances, tail entry holds the new timestamp.
- Window count:
  - Stimulus: WINDOW=100, 7 spikes in window 1 (one of them at wc=99), 0 spikes in window 2.
  - Required: win_valid pulses at cycles 100 and 200; win_count=7, then 0.
- Enable gating and reset:
  - Stimulus: enable=0 for 20 cycles with spike_in=1.
  - Required: no events, `ts` frozen, no win_valid.
  - Then assert reset_n=0 mid-fill with 3 entries: all outputs return to reset values, FIFO empty.
- SPIKE_EDGE_DETECT_EN defined:
  - Stimulus: spike_in high for 4 cycles from ts=3.
  - Required: exactly one event with timestamp 3; window accumulator counts 1.
